// File: rtl/axi_txn_arbiter_if.sv
// Control bundle between the requester blocks, the arbiter and the shared AXI transaction engine.
// The master modport is the arbiter side; slave is the requesters/engine side.
interface axi_txn_arbiter_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned ADDR_W = 32
);
    logic [N_REQ-1:0]        REQ;
    logic [N_REQ*ADDR_W-1:0] REQ_ADDR;
    logic [N_REQ-1:0]        GNT;
    logic [N_REQ-1:0]        REQ_DONE;
    logic [N_REQ-1:0]        REQ_ERROR;
    logic                    M_INIT_AXI_TXN;
    logic [ADDR_W-1:0]       M_TXN_BASE_ADDR;
    logic                    M_TXN_DONE;
    logic                    M_ERROR;
    logic                    BUSY;

    modport master (
        input  REQ, REQ_ADDR, M_TXN_DONE, M_ERROR,
        output GNT, REQ_DONE, REQ_ERROR, M_INIT_AXI_TXN, M_TXN_BASE_ADDR, BUSY
    );

    modport slave (
        output REQ, REQ_ADDR, M_TXN_DONE, M_ERROR,
        input  GNT, REQ_DONE, REQ_ERROR, M_INIT_AXI_TXN, M_TXN_BASE_ADDR, BUSY
    );
endinterface

// File: rtl/axi_txn_arbiter.sv
// Round-robin arbiter sharing one AXI transaction engine between N_REQ requesters.
// Define AXI_TXN_ARB_TIMEOUT_EN to add the WAIT-state watchdog and the TIMEOUT output.
module axi_txn_arbiter #(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic ACLK,
    input  logic ARESET,
`ifdef AXI_TXN_ARB_TIMEOUT_EN
    output logic TIMEOUT,
`endif
    axi_txn_arbiter_if.master txn_io
);
    localparam int unsigned IdxW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("axi_txn_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    done_pls_q, done_pls_d;
    logic [N_REQ-1:0]    err_pls_q, err_pls_d;
    logic [IdxW-1:0]     gidx_q, gidx_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                init_q, init_d;
    logic                busy_q, busy_d;
    logic                done_q;
    logic                done_evt;

    logic                pick_vld;
    logic [IdxW-1:0]     pick_idx;
    logic [ADDR_W-1:0]   pick_addr;
    int unsigned         cand;

`ifdef AXI_TXN_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            to_q, to_d;
`endif

    // Rising edge only, so a done level left high by the previous transaction is not a completion.
    assign done_evt = txn_io.M_TXN_DONE & ~done_q;

    always_comb begin
        pick_vld  = 1'b0;
        pick_idx  = '0;
        pick_addr = '0;
        cand      = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % N_REQ;
            if (!pick_vld && txn_io.REQ[cand[IdxW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IdxW-1:0];
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == IdxW'(i)) begin
                pick_addr = txn_io.REQ_ADDR[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gidx_d     = gidx_q;
        addr_d     = addr_q;
        rr_ptr_d   = rr_ptr_q;
        init_d     = 1'b0;
        done_pls_d = '0;
        err_pls_d  = '0;
`ifdef AXI_TXN_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        to_d       = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    gnt_d   = N_REQ'(1) << pick_idx;
                    gidx_d  = pick_idx;
                    addr_d  = pick_addr;
                    init_d  = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
`ifdef AXI_TXN_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (done_evt) begin
                    done_pls_d = gnt_q;
                    err_pls_d  = gnt_q & {N_REQ{txn_io.M_ERROR}};
                    state_d    = StResp;
                end
`ifdef AXI_TXN_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    done_pls_d = gnt_q;
                    err_pls_d  = gnt_q;
                    to_d       = 1'b1;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                gnt_d    = '0;
                rr_ptr_d = (gidx_q == IdxW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            done_pls_q <= '0;
            err_pls_q  <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            addr_q     <= '0;
            init_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef AXI_TXN_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_pls_q <= done_pls_d;
            err_pls_q  <= err_pls_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_q     <= addr_d;
            init_q     <= init_d;
            busy_q     <= busy_d;
            done_q     <= txn_io.M_TXN_DONE;
`ifdef AXI_TXN_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            to_q       <= to_d;
`endif
        end
    end

    assign txn_io.GNT             = gnt_q;
    assign txn_io.REQ_DONE        = done_pls_q;
    assign txn_io.REQ_ERROR       = err_pls_q;
    assign txn_io.M_INIT_AXI_TXN  = init_q;
    assign txn_io.M_TXN_BASE_ADDR = addr_q;
    assign txn_io.BUSY            = busy_q;
`ifdef AXI_TXN_ARB_TIMEOUT_EN
    assign TIMEOUT                = to_q;
`endif
endmodule
